rr_arbiter: RTL and testbench

RR_ARBITER -- requirements
Module: rr_arbiter

---
 rtl/arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 34 +++
 rtl/rr_arbiter.sv | 119 +++++++++++
 tb/tb_rr_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin arbiter.
// State enum and arbitration mode encodings.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Combinational winner search over a candidate vector.
// Round-robin scans upward from ptr with wrap; fixed picks lowest.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] cand,
    input  logic [W-1:0]     ptr,
    input  logic             mode,
    output logic [W-1:0]     win,
    output logic             found
);

    function automatic int slot(input int i, input logic [W-1:0] p,
                                input logic m);
        if (m == MODE_FIXED) return i;
        return (int'(p) + i) % N_REQ;
    endfunction

    // Scan from the far end so the nearest candidate is written last.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (cand[slot(i, ptr, mode)]) begin
                found = 1'b1;
                win   = W'(slot(i, ptr, mode));
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin / fixed-priority arbiter with bounded lock hold.
// Grant outputs are registered; one holder at a time.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         request,
    input  logic [N_REQ-1:0]         lock,
    input  logic                     mode,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     grant_valid
);

    localparam int W  = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_HOLD);
    localparam logic [CW-1:0]    CNT_MAX = CW'(MAX_HOLD - 1);
    localparam logic [W-1:0]     ID_MAX  = W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE     = N_REQ'(1);

    arb_state_t     state, state_n;
    logic [W-1:0]   h, h_n;
    logic [W-1:0]   ptr, ptr_n;
    logic [CW-1:0]  hold_cnt, cnt_n;

    logic [N_REQ-1:0] cand;
    logic [N_REQ-1:0] others;
    logic             arb;
    logic [W-1:0]     win;
    logic             found;

    rr_pick #(
        .N_REQ (N_REQ),
        .W     (W)
    ) u_pick (
        .cand  (cand),
        .ptr   (ptr),
        .mode  (mode),
        .win   (win),
        .found (found)
    );

    assign others = request & ~(ONE << h);

    always_comb begin
        state_n = state;
        h_n     = h;
        ptr_n   = ptr;
        cnt_n   = hold_cnt;
        cand    = '0;
        arb     = 1'b0;
        unique case (state)
            IDLE: begin
                if (|request) begin
                    cand = request;
                    arb  = 1'b1;
                end
            end
            GRANT: begin
                unique case (1'b1)
                    !request[h]: begin
                        cand = request;
                        arb  = 1'b1;
                    end
                    request[h] && !lock[h]: begin
                        cand = request;
                        arb  = 1'b1;
                    end
                    request[h] && lock[h]: begin
                        if (hold_cnt != CNT_MAX) begin
                            cnt_n = hold_cnt + CW'(1);
                        end else if (|others) begin
                            cand = others;
                            arb  = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            default: state_n = IDLE;
        endcase
        if (arb) begin
            cnt_n = '0;
            if (found) begin
                state_n = GRANT;
                h_n     = win;
                ptr_n   = (win == ID_MAX) ? '0 : win + W'(1);
            end else begin
                state_n = IDLE;
                h_n     = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            h           <= '0;
            ptr         <= '0;
            hold_cnt    <= '0;
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
        end else begin
            state       <= state_n;
            h           <= h_n;
            ptr         <= ptr_n;
            hold_cnt    <= cnt_n;
            grant       <= (state_n == GRANT) ? (ONE << h_n) : '0;
            grant_id    <= (state_n == GRANT) ? h_n : '0;
            grant_valid <= (state_n == GRANT);
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter: directed scenarios plus
// randomized traffic compared against a behavioural model.
module tb_rr_arbiter;

    localparam int N    = 4;
    localparam int MAXH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] request = '0;
    logic [3:0] lock = '0;
    logic       mode = 1'b0;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       grant_valid;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rr_arbiter #(
        .N_REQ    (N),
        .MAX_HOLD (MAXH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .request     (request),
        .lock        (lock),
        .mode        (mode),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    // holder = -1 means nobody holds the grant
    typedef struct {
        int holder;
        int ptr;
        int cnt;
    } mdl_t;

    mdl_t m = '{-1, 0, 0};

    function automatic int pick(input logic [3:0] c, input int p,
                                input logic md);
        for (int i = 0; i < N; i++) begin
            int j;
            j = md ? i : (p + i) % N;
            if (c[j]) return j;
        end
        return -1;
    endfunction

    function automatic mdl_t nxt(input mdl_t s, input logic [3:0] rq,
                                 input logic [3:0] lk, input logic md);
        mdl_t       r;
        logic [3:0] c;
        bit         arb;
        int         w;
        r   = s;
        c   = rq;
        arb = 0;
        if (s.holder < 0) begin
            arb = (rq != 0);
        end else if (!rq[s.holder] || !lk[s.holder]) begin
            arb = 1;
        end else if (s.cnt < MAXH - 1) begin
            r.cnt = s.cnt + 1;
        end else begin
            c[s.holder] = 1'b0;
            arb = (c != 0);
        end
        if (arb) begin
            w = pick(c, s.ptr, md);
            r.holder = w;
            r.cnt = 0;
            if (w >= 0) r.ptr = (w + 1) % N;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= '{-1, 0, 0};
        else      m <= nxt(m, request, lock, mode);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model.grant", int'(grant),
            (m.holder < 0) ? 0 : (1 << m.holder));
        chk("model.grant_id", int'(grant_id),
            (m.holder < 0) ? 0 : m.holder);
        chk("model.valid", int'(grant_valid), (m.holder >= 0) ? 1 : 0);
        chk("onehot0", int'($onehot0(grant)), 1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_g(input string nm, input int g, input int id);
        tick();
        chk({nm, ".grant"}, int'(grant), g);
        chk({nm, ".id"}, int'(grant_id), id);
        chk({nm, ".valid"}, int'(grant_valid), (g != 0) ? 1 : 0);
    endtask

    initial begin
        repeat (2) tick();
        chk("reset.grant", int'(grant), 0);
        chk("reset.id", int'(grant_id), 0);
        chk("reset.valid", int'(grant_valid), 0);
        rst = 1'b1;

        mode = 1'b0; lock = 4'b0000; request = 4'b1111;
        expect_g("rr0", 4'b0001, 0);
        expect_g("rr1", 4'b0010, 1);
        expect_g("rr2", 4'b0100, 2);
        expect_g("rr3", 4'b1000, 3);
        expect_g("rr4", 4'b0001, 0);

        mode = 1'b1; request = 4'b1010;
        for (int i = 0; i < 5; i++) expect_g("fixed", 4'b0010, 1);

        mode = 1'b0; request = 4'b0011; lock = 4'b0001;
        for (int i = 0; i < 4; i++) expect_g("lockhold", 4'b0001, 0);
        expect_g("lockexpire", 4'b0010, 1);

        request = 4'b0100; lock = 4'b0100;
        for (int i = 0; i < 10; i++) expect_g("sole_lock", 4'b0100, 2);
        chk("sole_lock.hold_cnt", int'(dut.hold_cnt), MAXH - 1);

        request = 4'b0001; lock = 4'b0000;
        expect_g("handoff_a", 4'b0001, 0);
        request = 4'b1000;
        expect_g("handoff_b", 4'b1000, 3);

        request = 4'b0100; lock = 4'b0100;
        for (int i = 0; i < 3; i++) expect_g("prereset", 4'b0100, 2);
        rst = 1'b0;
        #2;
        chk("async_rst.grant", int'(grant), 0);
        chk("async_rst.valid", int'(grant_valid), 0);
        #1;
        rst = 1'b1;
        request = 4'b1001; lock = 4'b0000;
        expect_g("post_rst", 4'b0001, 0);

        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0)
                request = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) lock = 4'hF;
            else                           lock = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            if (c == 300) begin
                rst = 1'b0;
                #2;
                rst = 1'b1;
            end
            tick();
        end

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
